// File: rtl/bt_pkg.sv
// Shared types and constants for the BTB update path.
//   bt_rec_t  : one resolved-branch record as held in the update FIFO.
//   BTUpdate  : 67-bit BTB update word. The two reserved bits sit at [35] and [3].
//   bt_issue  : turns a stored record into an update word with valid set.
package bt_pkg;

    localparam int unsigned BTU_W       = 67;
    localparam int unsigned BTU_SRC_LSB = 36;
    localparam int unsigned BTU_DST_LSB = 4;

    typedef struct packed {
        logic [30:0] src;
        logic [30:0] dst;
        logic        isJump;
        logic        compr;
    } bt_rec_t;

    typedef struct packed {
        logic [30:0] src;     // [66:36]
        logic        rsvd35;  // [35]
        logic [30:0] dst;     // [34:4]
        logic        rsvd3;   // [3]
        logic        isJump;  // [2]
        logic        compr;   // [1]
        logic        valid;   // [0]
    } BTUpdate;

    function automatic BTUpdate bt_issue(input bt_rec_t r);
        BTUpdate u;
        u        = '0;
        u.src    = r.src;
        u.dst    = r.dst;
        u.isJump = r.isJump;
        u.compr  = r.compr;
        u.valid  = 1'b1;
        return u;
    endfunction

endpackage

// File: rtl/bt_update_fifo.sv
// Dual-write, single-read circular buffer of branch records.
// Ports:
//   clk, rst          clock, async active-high reset
//   wr0_en/wr0_data   first write, lands at the write pointer
//   wr1_en/wr1_data   second write, lands after wr0 when both are enabled
//   pop               remove the head entry this edge
//   head              record at the read pointer
//   count             number of occupied entries
//   full              registered (count after this edge == DEPTH)
//   keep              per-slot flag: occupied and not being popped this cycle
//   entry_src         source PC of every slot, for duplicate matching
module bt_update_fifo
    import bt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr0_en,
    input  bt_rec_t                           wr0_data,
    input  logic                              wr1_en,
    input  bt_rec_t                           wr1_data,
    input  logic                              pop,
    output bt_rec_t                           head,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              full,
    output logic [DEPTH-1:0]                  keep,
    output logic [DEPTH-1:0][30:0]            entry_src
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    bt_rec_t        mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count_next;
    logic [PW-1:0]  wr1_ptr;

    assign count_next = count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
    assign wr1_ptr    = wr0_en ? wr_ptr + PW'(1) : wr_ptr;
    assign head       = mem[rd_ptr];

    always_comb begin
        keep      = '0;
        entry_src = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off          = PW'(i) - rd_ptr;
            keep[i]      = ({1'b0, off} < count) && !(pop && (PW'(i) == rd_ptr));
            entry_src[i] = mem[i].src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(wr0_en) + PW'(wr1_en);
            count  <= count_next;
            full   <= (count_next == CW'(DEPTH));
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]  <= wr0_data;
        if (wr1_en) mem[wr1_ptr] <= wr1_data;
    end

endmodule

// File: rtl/bt_update_queue.sv
// Collects resolved branches from two execution ports and feeds the BTB one
// update per cycle, suppressing duplicate source PCs and dropping on overflow.
// Ports:
//   clk, rst                    clock, async active-high reset
//   IN_br{0,1}Valid/Src/Dst/IsJump/Compr   branch records, port 0 has priority
//   IN_stall                    BTB busy: no issue, inputs still queued
//   OUT_btUpdate                registered 67-bit update word, [0] = valid
//   OUT_full                    FIFO holds DEPTH entries
//   OUT_dropCount               saturating count of overflow drops
module bt_update_queue
    import bt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_br0Valid,
    input  logic [30:0]       IN_br0Src,
    input  logic [30:0]       IN_br0Dst,
    input  logic              IN_br0IsJump,
    input  logic              IN_br0Compr,
    input  logic              IN_br1Valid,
    input  logic [30:0]       IN_br1Src,
    input  logic [30:0]       IN_br1Dst,
    input  logic              IN_br1IsJump,
    input  logic              IN_br1Compr,
    input  logic              IN_stall,
    output logic [BTU_W-1:0]  OUT_btUpdate,
    output logic              OUT_full,
    output logic [CNT_W-1:0]  OUT_dropCount
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = CNT_W + 1;

    bt_rec_t                rec0, rec1, head;
    logic [CW-1:0]          count;
    logic [DEPTH-1:0]       keep;
    logic [DEPTH-1:0][30:0] entry_src;
    logic                   pop;
    logic                   dup0_q, dup1_q, acc0, acc1;
    logic                   bypass, byp0, byp1, want0, want1, wr0, wr1;
    logic [CW-1:0]          free_slots;
    logic [1:0]             ndrop;
    logic [DW-1:0]          drop_sum;
    logic [CNT_W-1:0]       drop_cnt, drop_next;
    BTUpdate                out_q;

    assign rec0 = {IN_br0Src, IN_br0Dst, IN_br0IsJump, IN_br0Compr};
    assign rec1 = {IN_br1Src, IN_br1Dst, IN_br1IsJump, IN_br1Compr};
    assign pop  = !IN_stall && (count != '0);

    always_comb begin
        dup0_q = 1'b0;
        dup1_q = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (keep[i] && (entry_src[i] == IN_br0Src)) dup0_q = 1'b1;
            if (keep[i] && (entry_src[i] == IN_br1Src)) dup1_q = 1'b1;
        end
        acc0 = IN_br0Valid && !dup0_q;
        // Matching an accepted port-0 record also covers the case where that
        // record is the one being bypassed.
        acc1 = IN_br1Valid && !dup1_q && !(acc0 && (IN_br1Src == IN_br0Src));

        bypass = !IN_stall && (count == '0) && (acc0 || acc1);
        byp0   = bypass && acc0;
        byp1   = bypass && !acc0;
        want0  = acc0 && !byp0;
        want1  = acc1 && !byp1;

        free_slots = CW'(DEPTH) - count + CW'(pop);
        wr0        = want0 && (free_slots >= CW'(1));
        wr1        = want1 && (free_slots >= (wr0 ? CW'(2) : CW'(1)));
        ndrop      = 2'(want0 && !wr0) + 2'(want1 && !wr1);

        drop_sum  = {1'b0, drop_cnt} + DW'(ndrop);
        drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    bt_update_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0),
        .wr0_data (rec0),
        .wr1_en   (wr1),
        .wr1_data (rec1),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (OUT_full),
        .keep     (keep),
        .entry_src(entry_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= '0;
            drop_cnt <= '0;
        end else begin
            out_q.valid <= 1'b0;
            if (pop)       out_q <= bt_issue(head);
            else if (byp0) out_q <= bt_issue(rec0);
            else if (byp1) out_q <= bt_issue(rec1);
            drop_cnt <= drop_next;
        end
    end

    assign OUT_btUpdate  = out_q;
    assign OUT_dropCount = drop_cnt;

endmodule

// File: tb/tb_bt_update_queue.sv
module tb_bt_update_queue;
    import bt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IN_br0Valid, IN_br0IsJump, IN_br0Compr;
    logic [30:0] IN_br0Src, IN_br0Dst;
    logic        IN_br1Valid, IN_br1IsJump, IN_br1Compr;
    logic [30:0] IN_br1Src, IN_br1Dst;
    logic        IN_stall;
    logic [66:0] OUT_btUpdate;
    logic        OUT_full;
    logic [7:0]  OUT_dropCount;

    int checks   = 0;
    int failures = 0;
    logic [66:0] exp_q [$];

    bt_update_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .IN_br0Valid(IN_br0Valid), .IN_br0Src(IN_br0Src), .IN_br0Dst(IN_br0Dst),
        .IN_br0IsJump(IN_br0IsJump), .IN_br0Compr(IN_br0Compr),
        .IN_br1Valid(IN_br1Valid), .IN_br1Src(IN_br1Src), .IN_br1Dst(IN_br1Dst),
        .IN_br1IsJump(IN_br1IsJump), .IN_br1Compr(IN_br1Compr),
        .IN_stall(IN_stall),
        .OUT_btUpdate(OUT_btUpdate), .OUT_full(OUT_full), .OUT_dropCount(OUT_dropCount)
    );

    always #5 clk = ~clk;

    function automatic logic [66:0] mk_word(input logic [30:0] s, input logic [30:0] d,
                                            input logic j, input logic c);
        return {s, 1'b0, d, 1'b0, j, c, 1'b1};
    endfunction

    task automatic expect_rec(input logic [30:0] s, input logic [30:0] d,
                              input logic j, input logic c);
        exp_q.push_back(mk_word(s, d, j, c));
    endtask

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_p0(input logic [30:0] s, input logic [30:0] d, input logic j, input logic c);
        IN_br0Valid = 1'b1; IN_br0Src = s; IN_br0Dst = d; IN_br0IsJump = j; IN_br0Compr = c;
    endtask

    task automatic set_p1(input logic [30:0] s, input logic [30:0] d, input logic j, input logic c);
        IN_br1Valid = 1'b1; IN_br1Src = s; IN_br1Dst = d; IN_br1IsJump = j; IN_br1Compr = c;
    endtask

    task automatic clear_in();
        IN_br0Valid = 1'b0; IN_br0Src = '0; IN_br0Dst = '0; IN_br0IsJump = 1'b0; IN_br0Compr = 1'b0;
        IN_br1Valid = 1'b0; IN_br1Src = '0; IN_br1Dst = '0; IN_br1IsJump = 1'b0; IN_br1Compr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every issued update must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && OUT_btUpdate[0]) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got=%h expected=none", OUT_btUpdate);
            end else begin
                logic [66:0] e;
                e = exp_q.pop_front();
                if (OUT_btUpdate !== e) begin
                    failures++;
                    $display("FAIL issue_order: got=%h expected=%h", OUT_btUpdate, e);
                end
            end
        end
    end

    initial begin
        clear_in();
        IN_stall = 1'b0;
        rst      = 1'b1;
        repeat (3) step();
        check("reset_out", OUT_btUpdate, '0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_out",  OUT_btUpdate, '0);
            check("idle_full", 67'(OUT_full), 67'(0));
            check("idle_drop", 67'(OUT_dropCount), 67'(0));
        end

        // Single record on port 0, bypassed with one-cycle latency
        expect_rec(31'h100, 31'h200, 1'b1, 1'b0);
        set_p0(31'h100, 31'h200, 1'b1, 1'b0);
        step();
        clear_in();
        check("single_valid", 67'(OUT_btUpdate[0]), 67'(1));
        check("single_src",   67'(OUT_btUpdate[BTU_SRC_LSB +: 31]), 67'(31'h100));
        check("single_dst",   67'(OUT_btUpdate[BTU_DST_LSB +: 31]), 67'(31'h200));
        check("single_jump",  67'(OUT_btUpdate[2]), 67'(1));
        step();
        check("single_once",  67'(OUT_btUpdate[0]), 67'(0));

        // Both ports: port 0 bypassed, port 1 issued from the FIFO next cycle
        expect_rec(31'h10, 31'h11, 1'b0, 1'b1);
        expect_rec(31'h20, 31'h21, 1'b1, 1'b0);
        set_p0(31'h10, 31'h11, 1'b0, 1'b1);
        set_p1(31'h20, 31'h21, 1'b1, 1'b0);
        step();
        clear_in();
        check("dual_first_src",  67'(OUT_btUpdate[BTU_SRC_LSB +: 31]), 67'(31'h10));
        step();
        check("dual_second_src", 67'(OUT_btUpdate[BTU_SRC_LSB +: 31]), 67'(31'h20));
        check("dual_second_vld", 67'(OUT_btUpdate[0]), 67'(1));
        step();
        check("dual_after",      67'(OUT_btUpdate[0]), 67'(0));

        // Duplicate across ports in the same cycle: only port 0 issues
        expect_rec(31'h40, 31'h41, 1'b0, 1'b0);
        set_p0(31'h40, 31'h41, 1'b0, 1'b0);
        set_p1(31'h40, 31'h42, 1'b1, 1'b1);
        step();
        clear_in();
        step();
        check("dup_pair_once", 67'(OUT_btUpdate[0]), 67'(0));

        // Duplicate against an entry held in the FIFO under stall
        IN_stall = 1'b1;
        expect_rec(31'h40, 31'h43, 1'b0, 1'b0);
        set_p0(31'h40, 31'h43, 1'b0, 1'b0);
        step();
        set_p0(31'h40, 31'h44, 1'b1, 1'b0);
        step();
        clear_in();
        check("dup_fifo_drop", 67'(OUT_dropCount), 67'(0));
        check("stall_no_vld",  67'(OUT_btUpdate[0]), 67'(0));
        IN_stall = 1'b0;
        step();
        check("dup_fifo_issue", 67'(OUT_btUpdate[BTU_DST_LSB +: 31]), 67'(31'h43));
        step();
        check("dup_fifo_gone",  67'(OUT_btUpdate[0]), 67'(0));

        // Overflow under stall: six records, four fit, two dropped
        IN_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [30:0] s0, s1;
            s0 = 31'h51 + 31'(2 * k);
            s1 = s0 + 31'd1;
            if (k < 2) begin
                expect_rec(s0, s0 + 31'h100, 1'b0, 1'b0);
                expect_rec(s1, s1 + 31'h100, 1'b0, 1'b0);
            end
            set_p0(s0, s0 + 31'h100, 1'b0, 1'b0);
            set_p1(s1, s1 + 31'h100, 1'b0, 1'b0);
            step();
            if (k == 1) begin
                check("ovf_full_at4",  67'(OUT_full), 67'(1));
                check("ovf_drop_at4",  67'(OUT_dropCount), 67'(0));
            end
        end
        clear_in();
        check("ovf_full", 67'(OUT_full), 67'(1));
        check("ovf_drop", 67'(OUT_dropCount), 67'(2));
        IN_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("ovf_drain_vld", 67'(OUT_btUpdate[0]), 67'(1));
        end
        check("ovf_drain_full", 67'(OUT_full), 67'(0));
        step();
        check("ovf_drain_end", 67'(OUT_btUpdate[0]), 67'(0));

        // Full FIFO with a simultaneous pop accepts exactly one new record
        IN_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [30:0] s0;
            s0 = 31'h61 + 31'(2 * k);
            expect_rec(s0, 31'h7000, 1'b1, 1'b1);
            expect_rec(s0 + 31'd1, 31'h7001, 1'b0, 1'b1);
            set_p0(s0, 31'h7000, 1'b1, 1'b1);
            set_p1(s0 + 31'd1, 31'h7001, 1'b0, 1'b1);
            step();
        end
        IN_stall = 1'b0;
        expect_rec(31'h65, 31'h7002, 1'b0, 1'b0);
        set_p0(31'h65, 31'h7002, 1'b0, 1'b0);
        set_p1(31'h66, 31'h7003, 1'b0, 1'b0);
        step();
        clear_in();
        check("popfull_src",  67'(OUT_btUpdate[BTU_SRC_LSB +: 31]), 67'(31'h61));
        check("popfull_full", 67'(OUT_full), 67'(1));
        check("popfull_drop", 67'(OUT_dropCount), 67'(3));
        repeat (4) step();
        check("popfull_last", 67'(OUT_btUpdate[BTU_SRC_LSB +: 31]), 67'(31'h65));
        step();
        check("popfull_end",  67'(OUT_btUpdate[0]), 67'(0));

        // Async reset mid-cycle with three queued records (never expected to issue)
        IN_stall = 1'b1;
        set_p0(31'h71, 31'h1, 1'b0, 1'b0);
        set_p1(31'h72, 31'h2, 1'b0, 1'b0);
        step();
        clear_in();
        set_p0(31'h73, 31'h3, 1'b0, 1'b0);
        step();
        clear_in();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out",  OUT_btUpdate, '0);
        check("arst_drop", 67'(OUT_dropCount), 67'(0));
        check("arst_full", 67'(OUT_full), 67'(0));
        IN_stall = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("arst_no_stale", 67'(OUT_btUpdate[0]), 67'(0));
        end

        check("scoreboard_empty", 67'(exp_q.size()), 67'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
